// File: rtl/nios2_soc_mem_copier.sv
// Avalon-MM word-serial block copier: one read, then one write, per word.
// Optional MEM_COPIER_CHECKSUM_EN adds a running 32-bit sum of the words read.
module nios2_soc_mem_copier #(
   parameter int ADDR_W = 13,
   parameter int LEN_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic [3:0]        avm_byteenable,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   output logic [2:0]        dbg_state
`ifdef MEM_COPIER_CHECKSUM_EN
   ,
   output logic [31:0]       checksum
`endif
);

   // Handshake: a request (avm_read/avm_write) is accepted on the rising edge where
   // avm_waitrequest is low; address and command are held unchanged until then.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RD   = 3'd2,
      RDW  = 3'd3,
      WR   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] src_q, dst_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [31:0]       wdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    state_nx = (cnt_q == '0) ? DONE : RD;
         RD:      if (!avm_waitrequest) state_nx = RDW;
         RDW:     if (avm_readdatavalid) state_nx = WR;
         WR:      if (!avm_waitrequest) state_nx = (cnt_q == LEN_W'(1)) ? DONE : RD;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy           = 1'b0;
      done           = 1'b0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_address    = '0;
      avm_byteenable = 4'h0;
      case (state)
         LOAD: busy = 1'b1;
         RD: begin
            busy           = 1'b1;
            avm_read       = 1'b1;
            avm_address    = src_q;
            avm_byteenable = 4'hF;
         end
         RDW: busy = 1'b1;
         WR: begin
            busy           = 1'b1;
            avm_write      = 1'b1;
            avm_address    = dst_q;
            avm_byteenable = 4'hF;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign avm_writedata = wdata_q;
   assign dbg_state     = state;

   // Parameters are captured on the accepted start so LOAD can already test the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
      end else begin
         if (state == IDLE && start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            cnt_q <= len;
         end
         if (state == RDW && avm_readdatavalid) wdata_q <= avm_readdata;
         if (state == WR && !avm_waitrequest) begin
            src_q <= src_q + ADDR_W'(1);
            dst_q <= dst_q + ADDR_W'(1);
            cnt_q <= cnt_q - LEN_W'(1);
         end
      end
   end

`ifdef MEM_COPIER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 checksum <= '0;
      else if (state == LOAD)                    checksum <= '0;
      else if (state == RDW && avm_readdatavalid) checksum <= checksum + avm_readdata;
   end
`endif

endmodule

// File: tb/tb_nios2_soc_mem_copier.sv
// Bench for nios2_soc_mem_copier: Avalon slave memory model plus an ascending-copy reference.
// Build with MEM_COPIER_CHECKSUM_EN defined to also check the checksum output.
module tb_nios2_soc_mem_copier;
   localparam int AW = 13;
   localparam int LW = 13;
   localparam int MEM_WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [AW-1:0] src_addr, dst_addr;
   logic [LW-1:0] len;
   logic          busy, done, avm_read, avm_write;
   logic [AW-1:0] avm_address;
   logic [3:0]    avm_byteenable;
   logic [31:0]   avm_writedata, avm_readdata;
   logic          avm_readdatavalid, avm_waitrequest;
   logic [2:0]    dbg_state;
`ifdef MEM_COPIER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   nios2_soc_mem_copier #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done),
      .avm_address(avm_address), .avm_byteenable(avm_byteenable),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest),
      .dbg_state(dbg_state)
`ifdef MEM_COPIER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // slave memory, reference memory and slave configuration
   logic [31:0]   mem     [MEM_WORDS];
   logic [31:0]   ref_mem [MEM_WORDS];
   int            stall_cfg = 0;
   int            lat_cfg = 0;
   bit            noise = 1'b0;
   bit            rd_pending = 1'b0;
   logic [AW-1:0] rd_addr;
   int            rd_wait = 0;
   int            stall_left = 0;
   logic [AW-1:0] rd_log[$];
   logic [AW-1:0] wr_log[$];
   int            proto_err = 0;
   int            done_cnt = 0;
   bit            prev_stalled = 1'b0;
   logic [AW-1:0] prev_addr;
   logic          prev_rd, prev_wr;

   // Slave decisions are made on the falling edge and take effect at the next rising edge.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (reset) begin
         rd_pending        = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_waitrequest   = 1'b0;
         stall_left        = stall_cfg;
         prev_stalled      = 1'b0;
      end else begin
         if (avm_read && avm_write) proto_err++;
         if (avm_byteenable !== ((avm_read || avm_write) ? 4'hF : 4'h0)) proto_err++;
         if (prev_stalled && (avm_address !== prev_addr || avm_read !== prev_rd || avm_write !== prev_wr))
            proto_err++;
         if (avm_read && rd_pending) proto_err++;
         if (rd_pending) begin
            if (rd_wait > 0) begin
               avm_readdatavalid = 1'b0;
               rd_wait--;
            end else begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = mem[rd_addr];
               rd_pending        = 1'b0;
            end
         end else begin
            avm_readdatavalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            avm_readdata      = $urandom;
         end
         if (avm_read || avm_write) begin
            if (stall_left > 0) begin
               avm_waitrequest = 1'b1;
               stall_left--;
            end else begin
               avm_waitrequest = 1'b0;
               stall_left      = stall_cfg;
               if (avm_read) begin
                  rd_pending = 1'b1;
                  rd_addr    = avm_address;
                  rd_wait    = lat_cfg;
                  rd_log.push_back(avm_address);
               end else begin
                  mem[avm_address] = avm_writedata;
                  wr_log.push_back(avm_address);
               end
            end
         end else begin
            avm_waitrequest = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            stall_left      = stall_cfg;
         end
         prev_stalled = (avm_read || avm_write) && avm_waitrequest;
         prev_addr    = avm_address;
         prev_rd      = avm_read;
         prev_wr      = avm_write;
      end
   end

   task automatic fill_mem();
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done, avm_read, avm_write} !== 4'b0 || avm_address !== '0 ||
          avm_byteenable !== 4'h0 || avm_writedata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b addr=%h be=%h wd=%h, want all 0",
                  busy, done, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata);
      end
`ifdef MEM_COPIER_CHECKSUM_EN
      vectors++;
      if (checksum !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_checksum: got %h want 0", checksum);
      end
`endif
      reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // Copies n words s->d, checking timing (zero-wait only), traffic, memory and checksum.
   // inj > 0 pulses a conflicting start in that cycle; restart pulses one during done.
   task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                           input bit zero_wait, input int inj, input bit restart);
      logic [AW-1:0] exp_rd[$];
      logic [AW-1:0] exp_wr[$];
      logic [AW-1:0] a, b;
      logic [31:0]   sum;
      int            t0, dc, err0, dc0, bad;
      bit            got;
      ref_mem = mem;
      sum = 32'h0;
      for (int i = 0; i < int'(n); i++) begin
         a = s + AW'(i);
         b = d + AW'(i);
         exp_rd.push_back(a);
         exp_wr.push_back(b);
         sum = sum + ref_mem[a];
         ref_mem[b] = ref_mem[a];
      end
      rd_log.delete();
      wr_log.delete();
      err0 = proto_err;
      dc = 0;
      @(posedge clk);
      #1;
      start = 1'b1;
      src_addr = s;
      dst_addr = d;
      len = n;
      t0 = cyc;
      dc0 = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
      got = 1'b0;
      for (int k = 1; k < 4000 && !got; k++) begin
         @(negedge clk);
         if (k == inj) begin
            start = 1'b1;
            src_addr = ~s;
            dst_addr = s;
            len = n + LW'(1);
         end else begin
            start = 1'b0;
         end
         if (done) begin
            got = 1'b1;
            dc = cyc - t0;
         end else begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL busy_during_copy: cycle %0d busy=%b want 1", k, busy);
            end
         end
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL done_timeout: no done pulse, state=%0d", dbg_state);
      end else begin
         vectors++;
         if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_done: got %b want 0", busy);
         end
`ifdef MEM_COPIER_CHECKSUM_EN
         vectors++;
         if (checksum !== sum) begin
            miscompares++;
            $display("FAIL checksum: got %h want %h", checksum, sum);
         end
`endif
      end
      if (zero_wait) begin
         vectors++;
         if (dc != ((n == 0) ? 2 : 2 + 3 * int'(n))) begin
            miscompares++;
            $display("FAIL done_cycle: got %0d want %0d", dc, (n == 0) ? 2 : 2 + 3 * int'(n));
         end
      end
      if (restart) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (done !== 1'b0 || done_cnt - dc0 != 1) begin
         miscompares++;
         $display("FAIL done_pulse: done=%b pulses=%0d want done=0 pulses=1", done, done_cnt - dc0);
      end
      if (restart) begin
         repeat (4) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || avm_read !== 1'b0) begin
               miscompares++;
               $display("FAIL start_at_done: busy=%b rd=%b want 0 0", busy, avm_read);
            end
         end
      end
      bad = (rd_log.size() != exp_rd.size()) ? 1 : 0;
      for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) if (rd_log[i] !== exp_rd[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL read_sequence: %0d reads, %0d bad, want %0d reads", rd_log.size(), bad, exp_rd.size());
      end
      bad = (wr_log.size() != exp_wr.size()) ? 1 : 0;
      for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) if (wr_log[i] !== exp_wr[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL write_sequence: %0d writes, %0d bad, want %0d writes", wr_log.size(), bad, exp_wr.size());
      end
      bad = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL memory_contents: %0d words differ, want 0", bad);
      end
      vectors++;
      if (proto_err != err0) begin
         miscompares++;
         $display("FAIL bus_protocol: %0d violations, want 0", proto_err - err0);
      end
   endtask

   task automatic test_basic_copy();
      stall_cfg = 0;
      lat_cfg = 0;
      noise = 1'b0;
      for (int i = 0; i < 4; i++) mem[13'h010 + i] = 32'(i + 1);
      run_copy(13'h010, 13'h100, 13'd4, 1'b1, 0, 1'b0);
      vectors++;
      if (mem[13'h100] !== 32'd1 || mem[13'h101] !== 32'd2 || mem[13'h102] !== 32'd3 || mem[13'h103] !== 32'd4) begin
         miscompares++;
         $display("FAIL basic_dest: got %0d %0d %0d %0d want 1 2 3 4",
                  mem[13'h100], mem[13'h101], mem[13'h102], mem[13'h103]);
      end
   endtask

   task automatic test_zero_len();
      run_copy(13'h040, 13'h050, 13'd0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_stalls();
      stall_cfg = 3;
      run_copy(13'h020, 13'h120, 13'd2, 1'b0, 0, 1'b0);
      stall_cfg = 0;
   endtask

   task automatic test_wrap();
      run_copy(13'h1FFE, 13'h0000, 13'd3, 1'b1, 0, 1'b0);
   endtask

   task automatic test_start_while_busy();
      run_copy(13'h060, 13'h160, 13'd4, 1'b1, 5, 1'b0);
      run_copy(13'h070, 13'h170, 13'd2, 1'b1, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_copy(13'h080, 13'h180, 13'd3, 1'b1, 0, 1'b1);
      run_copy(13'h180, 13'h300, 13'd3, 1'b1, 0, 1'b0);
      run_copy(13'h200, 13'h202, 13'd6, 1'b1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_copy();
      int  dc0, bad;
      bit  hit;
      ref_mem = mem;
      rd_log.delete();
      wr_log.delete();
      @(posedge clk);
      #1;
      start = 1'b1;
      src_addr = 13'h400;
      dst_addr = 13'h500;
      len = 13'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(posedge clk);
         #1;
         if (avm_write && wr_log.size() == 1) hit = 1'b1;
      end
      vectors++;
      if (!hit) begin
         miscompares++;
         $display("FAIL reset_mid_reach_wr: second write never seen, state=%0d", dbg_state);
      end
      dc0 = done_cnt;
      reset = 1'b1;
      #1;
      vectors++;
      if ({busy, done, avm_read, avm_write} !== 4'b0 || avm_address !== '0 ||
          avm_byteenable !== 4'h0 || avm_writedata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b rd=%b wr=%b addr=%h be=%h wd=%h, want all 0",
                  busy, done, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if (done_cnt != dc0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_abandon: done pulses=%0d busy=%b want 0 0", done_cnt - dc0, busy);
      end
      ref_mem[13'h500] = ref_mem[13'h400];
      bad = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL reset_mid_memory: %0d words differ, want 0", bad);
      end
      run_copy(13'h400, 13'h500, 13'd4, 1'b1, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [AW-1:0] s, d;
      logic [LW-1:0] n;
      noise = 1'b1;
      for (int it = 0; it < 25; it++) begin
         s = AW'($urandom);
         d = AW'($urandom);
         n = LW'($urandom_range(0, 10));
         stall_cfg = $urandom_range(0, 2);
         lat_cfg = $urandom_range(0, 2);
         run_copy(s, d, n, (stall_cfg == 0 && lat_cfg == 0), 0, 1'b0);
      end
      noise = 1'b0;
      stall_cfg = 0;
      lat_cfg = 0;
   endtask

   initial begin
      fill_mem();
      test_reset();
      test_basic_copy();
      test_zero_len();
      test_stalls();
      test_wrap();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_copy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
